// File: rtl/capture_controller.sv
// Acquisition sequencer: fills pre-trigger history, arms the trigger, then
// captures post-trigger samples into a circular sample RAM.
//
// state       | meaning
// S_IDLE      | waiting for an accepted start
// S_PRE       | storing the pre-trigger history
// S_ARM       | one-cycle arm pulse to the trigger block
// S_WAIT_TRIG | storing samples (wrapping freely) until run
// S_POST      | storing the programmed post-trigger samples
// S_DONE      | capture complete, addresses held for readout
module capture_controller #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH:0]     pre_count,
    input  logic [ADDR_WIDTH:0]     post_count,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic                    run,
    output logic                    arm,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0]   trig_addr,
    output logic [ADDR_WIDTH-1:0]   end_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARM,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH+1:0] DEPTH_L = {2'b01, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q,       ptr_d;
    logic                    wr_any_q,    wr_any_d;
    logic [ADDR_WIDTH:0]     pre_cnt_q,   pre_cnt_d;
    logic [ADDR_WIDTH:0]     post_cnt_q,  post_cnt_d;
    logic [ADDR_WIDTH:0]     pre_lat_q,   pre_lat_d;
    logic [ADDR_WIDTH:0]     post_lat_q,  post_lat_d;
    logic                    wr_en_q,     wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q,   wr_addr_d;
    logic [SAMPLE_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0]   end_addr_q,  end_addr_d;
    logic                    cfg_err_q,   cfg_err_d;

    logic                    capturing;
    logic [ADDR_WIDTH+1:0]   cnt_sum;
    logic [ADDR_WIDTH:0]     pre_cnt_inc;
    logic [ADDR_WIDTH:0]     post_cnt_inc;
    logic [ADDR_WIDTH-1:0]   last_wr_addr;

    assign capturing    = (state_q == S_PRE) || (state_q == S_ARM) ||
                          (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign cnt_sum      = {1'b0, pre_count} + {1'b0, post_count};
    assign pre_cnt_inc  = pre_cnt_q + 1'b1;
    assign post_cnt_inc = post_cnt_q + 1'b1;
    // Most recent write already issued; 0 when nothing has been written yet.
    assign last_wr_addr = wr_any_q ? (ptr_q - 1'b1) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            wr_any_q    <= 1'b0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            pre_lat_q   <= '0;
            post_lat_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
            end_addr_q  <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_any_q    <= wr_any_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            pre_lat_q   <= pre_lat_d;
            post_lat_q  <= post_lat_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_addr_q <= trig_addr_d;
            end_addr_q  <= end_addr_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wr_any_d    = wr_any_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        pre_lat_d   = pre_lat_q;
        post_lat_d  = post_lat_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_addr_d = trig_addr_q;
        end_addr_d  = end_addr_q;
        cfg_err_d   = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            if (capturing && valid) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = dataIn;
                ptr_d     = ptr_q + 1'b1;
                wr_any_d  = 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (cnt_sum > DEPTH_L) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            pre_lat_d  = pre_count;
                            post_lat_d = post_count;
                            pre_cnt_d  = '0;
                            post_cnt_d = '0;
                            ptr_d      = '0;
                            wr_any_d   = 1'b0;
                            // An empty history needs no PRE cycle at all.
                            state_d    = (pre_count == '0) ? S_ARM : S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (valid) begin
                        pre_cnt_d = pre_cnt_inc;
                        if (pre_cnt_inc == pre_lat_q) begin
                            state_d = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    state_d = S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    if (run) begin
                        trig_addr_d = last_wr_addr;
                        if (post_lat_q == '0) begin
                            end_addr_d = last_wr_addr;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (valid) begin
                        post_cnt_d = post_cnt_inc;
                        if (post_cnt_inc == post_lat_q) begin
                            end_addr_d = ptr_q;
                            state_d    = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign arm       = (state_q == S_ARM);
    assign busy      = capturing;
    assign done      = (state_q == S_DONE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign trig_addr = trig_addr_q;
    assign end_addr  = end_addr_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_capture_controller.sv
// Randomized bench for capture_controller; expectations come from a
// cycle-indexed stimulus table and arithmetic over it.
module tb_capture_controller;

    localparam int SW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int MAXC  = 320;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW:0]   pre_count;
    logic [AW:0]   post_count;
    logic          valid;
    logic [SW-1:0] dataIn;
    logic          run;
    logic          arm;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    bit            v_arr [MAXC];
    logic [SW-1:0] d_arr [MAXC];

    capture_controller #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .pre_count  (pre_count),
        .post_count (post_count),
        .valid      (valid),
        .dataIn     (dataIn),
        .run        (run),
        .arm        (arm),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit vget(input int k);
        if (k < 0 || k >= MAXC) return 1'b1;
        return v_arr[k];
    endfunction

    function automatic int count_valid(input int a, input int b);
        int s = 0;
        for (int c = a; c <= b; c++) if (vget(c)) s++;
        return s;
    endfunction

    function automatic int nth_valid(input int from, input int n);
        int s = 0;
        for (int c = from; c < MAXC; c++) begin
            if (v_arr[c]) begin
                s++;
                if (s == n) return c;
            end
        end
        return MAXC;
    endfunction

    // mode 0: random at pct%, 1: continuous, 2: every other cycle, 3: continuous ramp from 0x10
    task automatic gen_stim(input int mode, input int pct);
        for (int k = 0; k < MAXC; k++) begin
            case (mode)
                1, 3:    v_arr[k] = 1'b1;
                2:       v_arr[k] = (k % 2 == 1);
                default: v_arr[k] = ($urandom_range(0, 99) < pct);
            endcase
            if (k >= 150) v_arr[k] = 1'b1;
            d_arr[k] = (mode == 3) ? SW'(8'h10 + k - 1) : SW'($urandom);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, "_arm"},   {31'b0, arm},     0);
        check_val({name, "_we"},    {31'b0, wr_en},   0);
        check_val({name, "_waddr"}, {28'b0, wr_addr}, 0);
        check_val({name, "_wdata"}, {24'b0, wr_data}, 0);
        check_val({name, "_trig"},  {28'b0, trig_addr}, 0);
        check_val({name, "_end"},   {28'b0, end_addr}, 0);
        check_val({name, "_busy"},  {31'b0, busy},    0);
        check_val({name, "_done"},  {31'b0, done},    0);
        check_val({name, "_cerr"},  {31'b0, cfg_err}, 0);
    endtask

    // kill: 0 none, 1 abort+start at arm_cyc+kill_off, 2 async reset at run_cyc+kill_off
    task automatic do_capture(input string name, input int pre, input int post, input int d,
                              input int kill, input int kill_off, input bit extra_run);
        int arm_cyc, run_cyc, done_cyc, kill_cyc, last_cyc, run_drive, j;
        int exp_trig, exp_end, n;
        bit e_busy, e_done, e_arm, e_we;

        arm_cyc  = (pre == 0) ? 1 : nth_valid(1, pre) + 1;
        run_cyc  = arm_cyc + d;
        done_cyc = (post == 0) ? run_cyc + 1 : nth_valid(run_cyc + 1, post) + 1;
        n        = count_valid(1, run_cyc - 1);
        exp_trig = (n == 0) ? 0 : (n - 1) % DEPTH;
        exp_end  = (post == 0) ? exp_trig : (count_valid(1, done_cyc - 1) - 1) % DEPTH;
        kill_cyc = (kill == 1) ? arm_cyc + kill_off : (kill == 2) ? run_cyc + kill_off : MAXC;
        last_cyc = (kill == 1) ? kill_cyc + 4 : (kill == 2) ? kill_cyc : done_cyc + 4;
        run_drive = (kill == 1) ? kill_cyc + 1 : run_cyc;

        start      = 1'b1;
        abort      = 1'b0;
        pre_count  = (AW+1)'(pre);
        post_count = (AW+1)'(post);
        valid      = v_arr[0];
        dataIn     = d_arr[0];
        run        = 1'b0;

        for (int k = 1; k <= last_cyc; k++) begin
            @(posedge clock);
            #1;
            j      = k - 1;
            e_busy = (k < done_cyc);
            e_done = (k >= done_cyc);
            e_arm  = (k == arm_cyc);
            e_we   = (j >= 1) && (j < done_cyc) && (j < kill_cyc) && vget(j);
            if (kill == 1 && k > kill_cyc) begin
                e_busy = 1'b0;
                e_done = 1'b0;
                e_arm  = 1'b0;
            end
            check_val($sformatf("%s_arm@%0d", name, k),  {31'b0, arm},     {31'b0, e_arm});
            check_val($sformatf("%s_busy@%0d", name, k), {31'b0, busy},    {31'b0, e_busy});
            check_val($sformatf("%s_done@%0d", name, k), {31'b0, done},    {31'b0, e_done});
            check_val($sformatf("%s_cerr@%0d", name, k), {31'b0, cfg_err}, 0);
            check_val($sformatf("%s_we@%0d", name, k),   {31'b0, wr_en},   {31'b0, e_we});
            if (e_we) begin
                check_val($sformatf("%s_waddr@%0d", name, k), {28'b0, wr_addr},
                          (count_valid(1, j) - 1) % DEPTH);
                check_val($sformatf("%s_wdata@%0d", name, k), {24'b0, wr_data}, {24'b0, d_arr[j]});
            end
            if (kill != 1 && k == done_cyc) begin
                check_val($sformatf("%s_trig", name), {28'b0, trig_addr}, exp_trig);
                check_val($sformatf("%s_end", name),  {28'b0, end_addr},  exp_end);
            end

            start  = 1'b0;
            abort  = 1'b0;
            valid  = vget(k);
            dataIn = (k < MAXC) ? d_arr[k] : '0;
            run    = (k == run_drive) ||
                     (extra_run && (k == arm_cyc || k == run_cyc + 2 || (k == 1 && arm_cyc > 1)));
            if (kill == 1 && k == kill_cyc) begin
                abort = 1'b1;
                start = 1'b1;
            end
            if (kill == 2 && k == kill_cyc) begin
                #2 reset_n = 1'b0;
                #1 check_all_zero($sformatf("%s_rstnow", name));
                @(posedge clock);
                #1 check_all_zero($sformatf("%s_rsthold", name));
                start = 1'b0;
                valid = 1'b0;
                run   = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        run   = 1'b0;
        valid = 1'b0;
    endtask

    task automatic try_reject(input string name, input int pre, input int post, input bit exp_done);
        start      = 1'b1;
        pre_count  = (AW+1)'(pre);
        post_count = (AW+1)'(post);
        valid      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_val({name, "_cerr"}, {31'b0, cfg_err}, 1);
        check_val({name, "_busy"}, {31'b0, busy},    0);
        check_val({name, "_arm"},  {31'b0, arm},     0);
        check_val({name, "_we"},   {31'b0, wr_en},   0);
        check_val({name, "_done"}, {31'b0, done},    {31'b0, exp_done});
        @(posedge clock);
        #1;
        valid = 1'b0;
        check_val({name, "_cerr2"}, {31'b0, cfg_err}, 0);
        check_val({name, "_busy2"}, {31'b0, busy},    0);
        check_val({name, "_done2"}, {31'b0, done},    {31'b0, exp_done});
    endtask

    initial begin
        int pre, post;
        reset_n    = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pre_count  = '0;
        post_count = '0;
        valid      = 1'b0;
        dataIn     = '0;
        run        = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clock);
        #1 check_all_zero("reset_hold");
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;

        gen_stim(3, 100);
        do_capture("ramp", 3, 4, 5, 0, 0, 1'b0);

        gen_stim(1, 100);
        do_capture("zero", 0, 0, 3, 0, 0, 1'b1);

        try_reject("rej_done", 10, 7, 1'b1);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check_val("abort_idle_busy", {31'b0, busy}, 0);
        check_val("abort_idle_done", {31'b0, done}, 0);
        try_reject("rej_idle", 10, 7, 1'b0);
        try_reject("rej_pre16", 16, 1, 1'b0);

        gen_stim(2, 50);
        do_capture("wrap", 2, 3, 40, 0, 0, 1'b0);

        gen_stim(1, 100);
        do_capture("abort", 1, 2, 10, 1, 2, 1'b0);

        gen_stim(0, 60);
        do_capture("full16", 10, 6, 4, 0, 0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            pre  = $urandom_range(0, DEPTH);
            post = $urandom_range(0, DEPTH - pre);
            gen_stim(0, $urandom_range(30, 100));
            do_capture($sformatf("rnd%0d", i), pre, post, $urandom_range(1, 20), 0, 0, 1'($urandom));
        end

        gen_stim(1, 100);
        do_capture("midpost", 2, 8, 2, 2, 3, 1'b0);
        gen_stim(0, 70);
        do_capture("fresh", 2, 2, 3, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
